kalman_filter_mc: RTL and testbench
===================================

# kalman_filter_mc

Multi-channel, parametrised successor of the scalar one-dimensional Kalman smoother used on the ADC sample path. Time-multiplexes one shared predict/gain/update datapath across CH_N independent channels, each with its own stored estimate x and covariance p. Has valid/ready handshakes on input and output, runtime Q/R, and an iterative divider for the gain. It sits between the ADC capture block and the downstream posture/threshold logic.

## Interface
- DATA_W, 12: signed sample and estimate width.
- CH_N, 4: number of channels; CH_W = max(1, clog2(CH_N)).
- P_W, 16: unsigned covariance width. Q, R and p all use this width.
- FRAC_W, 12: gain fraction bits; gain K_W = FRAC_W+1 bits.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CH_W  channel of the offered sample.
- in_data  in  DATA_W  signed measurement z.
- q_cfg  in  P_W  process noise Q, sampled on input handshake.
- r_cfg  in  P_W  measurement noise R, sampled on input handshake.
- clr_en  in  1  one-cycle request to un-prime channel clr_ch.
- clr_ch  in  CH_W  channel to clear.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_ch  out  CH_W  channel of the result.
- out_data  out  DATA_W  filtered estimate.

## Operation
- Each channel holds x (DATA_W signed), p (P_W) and a primed bit. After reset: x=0, p=0, primed=0.
- States:
  - IDLE, in_ready=1. An input handshake (in_valid and in_ready) moves to PRED.
  - If the channel is unprimed: set x=z, p=R, primed=1, load out_data=z, go to OUT. The channel's first sample passes through unchanged.
- PRED: compute p_f = p+Q, saturated to 2^P_W-1; x_f = x; diff = z-x_f at DATA_W+1 bits.
- DIV: restoring divide K = (p_f<<FRAC_W)/(p_f+R), one quotient bit per cycle for K_W cycles. The denominator is P_W+1 bits. If the denominator is 0, K=0. K never exceeds 2^FRAC_W.
- MUL: compute m1 = K*diff and m2 = K*p_f at full width.
- ADD:
  - x_new = x_f + ((m1 + 2^(FRAC_W-1)) >>> FRAC_W), which rounds half up. x_new always lies between x_f and z, so no saturation is needed.
  - p_new = p_f - (m2 >> FRAC_W), floored at 0.
  - Write x_new and p_new to the channel, load out_data=x_new and out_ch, go to OUT.
- OUT: out_valid=1. An output handshake returns to IDLE. out_data and out_ch stay stable while out_ready is low.
- Clear requests:
  - A clear sets a pending bit for clr_ch in any state.
  - Pending bits are applied (primed=0) on any edge where the state is IDLE.
  - A clear and an input handshake for the same channel on the same edge: the clear wins, so the sample is treated as a first sample.
- in_ch >= CH_N: the sample is accepted, state is untouched, and out_data=in_data is returned.

## Timing
- Reset values: in_ready=0 during reset and 1 after; out_valid=0, out_data=0, out_ch=0. All pending bits are cleared.
- Input handshake at edge E0. PRED runs in cycle 1, DIV in cycles 2..K_W+1, MUL in K_W+2, ADD in K_W+3.
- out_valid rises at E0+K_W+4 (17 cycles for FRAC_W=12).
- Unprimed path: out_valid rises at E0+2.
- Minimum spacing between accepted samples is K_W+5 cycles. This holds with out_ready held high, because the OUT→IDLE and IDLE→accept transitions each take one edge.
- in_ready is high only in IDLE. No new sample is accepted while a result is pending.
- rst_n asserted mid-operation: the FSM returns to IDLE, all channel state is reinitialised, and the in-flight result is discarded.

## Structure
- Package kalman_mc_pkg holds:
  - the state enum (IDLE, PRED, DIV, MUL, ADD, OUT);
  - width helper constants (CH_W, K_W and the product widths).
- Sub-module kf_seq_div: restoring divider with start/done, a parametrised width, and divide-by-zero reporting K=0.
- Channel state is held in register arrays with a single write port in ADD or PRED.

## Test plan
- CH_N=4, FRAC_W=12, Q=1, R=4, ch0, z=1000 (unprimed) → out 1000 at E0+2; p0=4.
- Same channel, z=1100 → p_f=5, K=2275, out 1056 at E0+17; p0=3.
- Alternate ch1 z=-500 and ch2 z=300, then ch1 z=-400 → the ch1 result uses only ch1 history; ch2 is unaffected.
- Q=0, R=0 after priming (p=0) → K=0 and out equals the previous x. Separately, p_f>0 with R=0 → K=4096 and out=z.
- Hold out_ready=0 for 10 cycles → out_data is stable and in_ready=0. The next sample is accepted only after the output handshake.
- Issue clr_en for ch0 during DIV, and rst_n low mid-DIV → the next ch0 sample passes through; after reset, out_valid=0 and the first sample passes through.

Source files
------------

// File: rtl/kalman_mc_pkg.sv
// Shared types and width helpers for the multi-channel Kalman smoother.
package kalman_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRED,
        DIV,
        MUL,
        ADD,
        OUT
    } state_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int k_width(input int frac_w);
        return frac_w + 1;
    endfunction

    // Signed gain times signed (DATA_W+1)-bit innovation.
    function automatic int m1_width(input int k_w, input int data_w);
        return k_w + data_w + 2;
    endfunction

    function automatic int m2_width(input int k_w, input int p_w);
        return k_w + p_w;
    endfunction

endpackage

// File: rtl/kf_seq_div.sv
// Restoring divider, one quotient bit per cycle; a zero denominator yields a zero quotient.
module kf_seq_div #(
    parameter int N_W = 28,
    parameter int D_W = 17,
    parameter int Q_W = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] num,
    input  logic [D_W-1:0] den,
    output logic           last,
    output logic [Q_W-1:0] quot
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic [D_W-1:0]   den_q, den_d;
    logic [Q_W-1:0]   low_q, low_d;
    logic [Q_W-1:0]   quot_q, quot_d;
    logic             dz_q, dz_d;
    logic [D_W:0]     trial;
    logic [D_W:0]     trial_sub;
    logic             fits;

    // The caller guarantees the quotient fits Q_W bits, so the upper numerator
    // bits are already smaller than the denominator and seed the remainder.
    assign trial     = {rem_q, low_q[Q_W-1]};
    assign trial_sub = trial - {1'b0, den_q};
    assign fits      = (trial >= {1'b0, den_q});
    // High during the cycle whose closing edge writes the final quotient bit.
    assign last      = busy_q && (cnt_q == CNT_W'(Q_W - 1));
    assign quot      = dz_q ? '0 : quot_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        den_d  = den_q;
        low_d  = low_q;
        quot_d = quot_q;
        dz_d   = dz_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = D_W'(num >> Q_W);
            low_d  = num[Q_W-1:0];
            den_d  = den;
            dz_d   = (den == '0);
            quot_d = '0;
        end else if (busy_q) begin
            rem_d  = fits ? D_W'(trial_sub) : D_W'(trial);
            quot_d = {quot_q[Q_W-2:0], fits};
            low_d  = low_q << 1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            low_q  <= '0;
            quot_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            low_q  <= low_d;
            quot_q <= quot_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/kalman_filter_mc.sv
// Time-multiplexed scalar Kalman smoother: one predict/gain/update datapath
// shared by CH_N channels, each keeping its own estimate, covariance and primed bit.
module kalman_filter_mc
    import kalman_mc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CH_N   = 4,
    parameter int P_W    = 16,
    parameter int FRAC_W = 12,
    localparam int CH_W  = ch_width(CH_N)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [P_W-1:0]           q_cfg,
    input  logic [P_W-1:0]           r_cfg,
    input  logic                     clr_en,
    input  logic [CH_W-1:0]          clr_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    output state_e                   dbg_state
);

    localparam int K_W  = k_width(FRAC_W);
    localparam int M1_W = m1_width(K_W, DATA_W);
    localparam int M2_W = m2_width(K_W, P_W);
    localparam int N_W  = P_W + FRAC_W;
    localparam int D_W  = P_W + 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_N);
    localparam logic signed [M1_W-1:0] RND = M1_W'(2 ** (FRAC_W - 1));

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] x_q [CH_N];
    logic signed [DATA_W-1:0] x_d [CH_N];
    logic [P_W-1:0]           p_q [CH_N];
    logic [P_W-1:0]           p_d [CH_N];
    logic [CH_N-1:0]          primed_q, primed_d;
    logic [CH_N-1:0]          pend_q, pend_d;
    logic [CH_N-1:0]          clr_vec;

    logic signed [DATA_W-1:0] z_q, z_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     ch_ok_q, ch_ok_d;
    logic [P_W-1:0]           qn_q, qn_d;
    logic [P_W-1:0]           rn_q, rn_d;
    logic [P_W-1:0]           pf_q, pf_d;
    logic signed [DATA_W-1:0] xf_q, xf_d;
    logic signed [DATA_W:0]   diff_q, diff_d;
    logic signed [M1_W-1:0]   m1_q, m1_d;
    logic [M2_W-1:0]          m2_q, m2_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;

    logic signed [DATA_W-1:0] cur_x;
    logic [P_W-1:0]           cur_p;
    logic [P_W:0]             p_sum;
    logic [P_W-1:0]           p_fc;
    logic [N_W-1:0]           div_num;
    logic [D_W-1:0]           div_den;
    logic                     div_start;
    logic                     div_last;
    logic [K_W-1:0]           k;
    logic signed [M1_W-1:0]   k_s, d_s, delta;
    logic [DATA_W:0]          x_sum;
    logic [M2_W-1:0]          m2_sh, pf_ext;
    logic [P_W-1:0]           p_new;

    assign cur_x   = x_q[ch_q];
    assign cur_p   = p_q[ch_q];
    assign p_sum   = {1'b0, cur_p} + {1'b0, qn_q};
    assign p_fc    = p_sum[P_W] ? '1 : p_sum[P_W-1:0];
    assign div_num = {p_fc, {FRAC_W{1'b0}}};
    assign div_den = {1'b0, p_fc} + {1'b0, rn_q};

    kf_seq_div #(
        .N_W(N_W),
        .D_W(D_W),
        .Q_W(K_W)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .start(div_start),
        .num  (div_num),
        .den  (div_den),
        .last (div_last),
        .quot (k)
    );

    assign k_s = M1_W'($signed({1'b0, k}));
    assign d_s = M1_W'(diff_q);

    // Arithmetic shift of the biased product rounds half up; the step never
    // overshoots the measurement because K <= 1.0.
    assign delta  = (m1_q + RND) >>> FRAC_W;
    assign x_sum  = {xf_q[DATA_W-1], xf_q} + (DATA_W + 1)'(delta);
    assign m2_sh  = m2_q >> FRAC_W;
    assign pf_ext = M2_W'(pf_q);
    assign p_new  = (m2_sh > pf_ext) ? '0 : P_W'(pf_ext - m2_sh);

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        p_d        = p_q;
        primed_d   = primed_q;
        pend_d     = pend_q;
        z_d        = z_q;
        ch_d       = ch_q;
        ch_ok_d    = ch_ok_q;
        qn_d       = qn_q;
        rn_d       = rn_q;
        pf_d       = pf_q;
        xf_d       = xf_q;
        diff_d     = diff_q;
        m1_d       = m1_q;
        m2_d       = m2_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        div_start  = 1'b0;
        clr_vec    = '0;

        if (clr_en && ({1'b0, clr_ch} < CH_LIM)) begin
            clr_vec[clr_ch] = 1'b1;
        end
        // Clears landing on the accept edge take effect before PRED reads primed.
        if (state_q == IDLE) begin
            primed_d = primed_q & ~(pend_q | clr_vec);
            pend_d   = '0;
        end else begin
            pend_d = pend_q | clr_vec;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    z_d     = in_data;
                    ch_d    = in_ch;
                    ch_ok_d = ({1'b0, in_ch} < CH_LIM);
                    qn_d    = q_cfg;
                    rn_d    = r_cfg;
                    state_d = PRED;
                end
            end
            PRED: begin
                if (!ch_ok_q) begin
                    out_data_d = z_q;
                    out_ch_d   = ch_q;
                    state_d    = OUT;
                end else if (!primed_q[ch_q]) begin
                    x_d[ch_q]      = z_q;
                    p_d[ch_q]      = rn_q;
                    primed_d[ch_q] = 1'b1;
                    out_data_d     = z_q;
                    out_ch_d       = ch_q;
                    state_d        = OUT;
                end else begin
                    pf_d      = p_fc;
                    xf_d      = cur_x;
                    diff_d    = {z_q[DATA_W-1], z_q} - {cur_x[DATA_W-1], cur_x};
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_last) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                m1_d    = k_s * d_s;
                m2_d    = M2_W'(k) * pf_ext;
                state_d = ADD;
            end
            ADD: begin
                x_d[ch_q]  = DATA_W'(x_sum);
                p_d[ch_q]  = p_new;
                out_data_d = DATA_W'(x_sum);
                out_ch_d   = ch_q;
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < CH_N; i++) begin
                x_q[i] <= '0;
                p_q[i] <= '0;
            end
            primed_q   <= '0;
            pend_q     <= '0;
            z_q        <= '0;
            ch_q       <= '0;
            ch_ok_q    <= 1'b0;
            qn_q       <= '0;
            rn_q       <= '0;
            pf_q       <= '0;
            xf_q       <= '0;
            diff_q     <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            p_q        <= p_d;
            primed_q   <= primed_d;
            pend_q     <= pend_d;
            z_q        <= z_d;
            ch_q       <= ch_d;
            ch_ok_q    <= ch_ok_d;
            qn_q       <= qn_d;
            rn_q       <= rn_d;
            pf_q       <= pf_d;
            xf_q       <= xf_d;
            diff_q     <= diff_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

endmodule

// File: tb/tb_kalman_filter_mc.sv
// Directed and randomized bench for kalman_filter_mc against an arithmetic model.
module tb_kalman_filter_mc;
    import kalman_mc_pkg::*;

    localparam int DATA_W = 12;
    localparam int CH_N   = 4;
    localparam int P_W    = 16;
    localparam int FRAC_W = 12;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch = '0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic [P_W-1:0]           q_cfg = '0;
    logic [P_W-1:0]           r_cfg = '0;
    logic                     clr_en = 1'b0;
    logic [CH_W-1:0]          clr_ch = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    state_e                   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state per channel.
    longint mx [CH_N];
    longint mp [CH_N];
    bit     mprim [CH_N];

    // Scoreboard: expected result, channel and latency in acceptance order.
    logic signed [DATA_W-1:0] exp_q [$];
    logic [CH_W-1:0]          ech_q [$];
    int                       lat_q [$];

    kalman_filter_mc #(
        .DATA_W(DATA_W),
        .CH_N  (CH_N),
        .P_W   (P_W),
        .FRAC_W(FRAC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .q_cfg    (q_cfg),
        .r_cfg    (r_cfg),
        .clr_en   (clr_en),
        .clr_ch   (clr_ch),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_data (out_data),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH_N; i++) begin
            mx[i] = 0;
            mp[i] = 0;
            mprim[i] = 0;
        end
        exp_q.delete();
        ech_q.delete();
        lat_q.delete();
    endtask

    // Filter step from the textbook equations with integer gain arithmetic.
    task automatic model_step(input int ch, input longint z, input longint q, input longint r);
        longint pf, den, k, t, stp, pn;
        if (!mprim[ch]) begin
            mx[ch] = z;
            mp[ch] = r;
            mprim[ch] = 1;
            lat_q.push_back(2);
        end else begin
            pf = mp[ch] + q;
            if (pf > 65535) pf = 65535;
            den = pf + r;
            k = (den == 0) ? 0 : (pf * 4096) / den;
            t = k * (z - mx[ch]) + 2048;
            stp = (t >= 0) ? t / 4096 : -((-t + 4095) / 4096);
            mx[ch] = mx[ch] + stp;
            pn = pf - (k * pf) / 4096;
            mp[ch] = (pn < 0) ? 0 : pn;
            lat_q.push_back(17);
        end
        exp_q.push_back(DATA_W'(mx[ch]));
        ech_q.push_back(CH_W'(ch));
    endtask

    // Driver: called at a negedge, returns at the negedge after the accept edge.
    task automatic send(input int ch, input int z, input int q, input int r,
                        input bit clr_same, output int acc);
        int w;
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(z);
        q_cfg    = P_W'(q);
        r_cfg    = P_W'(r);
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", (w >= 200) ? 1 : 0, 0);
        if (clr_same) begin
            clr_en = 1'b1;
            clr_ch = CH_W'(ch);
            mprim[ch] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clr_en   = 1'b0;
        acc      = cyc;
        model_step(ch, z, q, r);
    endtask

    // Collects one result, optionally pulsing a clear while it is in flight.
    task automatic receive(input int hold, input int clr_at, input int clr_c);
        int cnt;
        logic signed [DATA_W-1:0] e;
        logic [CH_W-1:0] ec;
        int el;
        cnt = 1;
        while (!out_valid && cnt < 100) begin
            clr_en = (cnt == clr_at);
            clr_ch = CH_W'(clr_c);
            if (cnt == clr_at) mprim[clr_c] = 0;
            @(negedge clk);
            cnt++;
        end
        clr_en = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e  = exp_q.pop_front();
        ec = ech_q.pop_front();
        el = lat_q.pop_front();
        check("latency", cnt, el);
        check("out_data", out_data, e);
        check("out_ch", out_ch, ec);
        for (int i = 0; i < hold; i++) begin
            check("in_ready_hold", in_ready, 0);
            @(negedge clk);
            check("out_data_stable", out_data, e);
            check("out_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        int a0, a1, ch, z, q, r;
        model_reset();
        // Reset values.
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_state", dbg_state, IDLE);

        // First sample passes through, then a filtered update and spacing.
        send(0, 1000, 1, 4, 0, a0);
        receive(0, -1, 0);
        send(0, 1100, 1, 4, 0, a0);
        check("known_value_1056", exp_q[0], 1056);
        receive(0, -1, 0);
        send(0, 1200, 1, 4, 0, a1);
        check("accept_spacing", a1 - a0, 18);
        receive(0, -1, 0);

        // Interleaved channels keep independent history.
        send(1, -500, 1, 4, 0, a0); receive(1, -1, 0);
        send(2, 300, 1, 4, 0, a0);  receive(0, -1, 0);
        send(1, -400, 1, 4, 0, a0); receive(2, -1, 0);
        send(2, 310, 1, 4, 0, a0);  receive(0, -1, 0);

        // Zero covariance and zero R corners.
        send(3, 700, 0, 0, 0, a0);  receive(0, -1, 0);
        send(3, 900, 0, 0, 0, a0);  receive(0, -1, 0);
        send(3, -100, 5, 0, 0, a0); receive(0, -1, 0);

        // Long output stall.
        send(1, 0, 1, 4, 0, a0);    receive(10, -1, 0);

        // Clear during the divide, then clear on the accept edge.
        send(0, 1300, 1, 4, 0, a0); receive(0, 5, 0);
        send(0, -200, 1, 4, 0, a0); receive(0, -1, 0);
        send(2, 50, 1, 4, 1, a0);   receive(0, -1, 0);

        // Covariance saturation.
        send(1, 100, 65535, 65535, 0, a0); receive(0, -1, 0);
        send(1, 2000, 65535, 3, 0, a0);    receive(0, -1, 0);

        // Reset in the middle of a divide.
        send(2, 900, 1, 4, 0, a0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_after_valid", out_valid, 0);
        check("midrst_after_data", out_data, 0);
        check("midrst_after_ready", in_ready, 1);
        send(2, 123, 1, 4, 0, a0); receive(0, -1, 0);
        send(2, 200, 1, 4, 0, a0); receive(0, -1, 0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            ch = $urandom_range(0, CH_N - 1);
            z  = int'($urandom_range(0, 4095)) - 2048;
            q  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 50);
            r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 50);
            send(ch, z, q, r, ($urandom_range(0, 7) == 0), a0);
            receive($urandom_range(0, 2), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
